// File: rtl/mac_pkg.sv
// Shared types and default widths for the dot-product MAC scheduler.
package mac_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select. The pointer marks the highest-priority requester
// and moves to one past the served requester when the caller strobes advance.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      scan_idx;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_idx = 32'(ptr_q) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = IDX_W'(scan_idx);
      end
    end
  end

  // Next pointer: one past the requester just served, modulo NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mac_dot_scheduler.sv
// Time-shares one multiply-accumulate datapath among NUM_REQ requesters.
// Each granted job accumulates req_len operand pairs and returns the sum
// tagged with the requester index.
module mac_dot_scheduler
  import mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OP_W    = mac_pkg::OP_W,
  parameter int unsigned ACC_W   = mac_pkg::ACC_W,
  parameter int unsigned LEN_W   = mac_pkg::LEN_W,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  input  logic                     op_valid,
  input  logic [OP_W-1:0]          op_a,
  input  logic [OP_W-1:0]          op_b,
  output logic                     op_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_overflow
);

  localparam int unsigned PROD_W = 2 * OP_W;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum;
  logic [LEN_W-1:0]  win_len;

  logic              arb_found;
  logic [ID_W-1:0]   arb_winner;
  logic              advance;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (advance),
    .last    (id_q),
    .found   (arb_found),
    .winner  (arb_winner)
  );

  // Zero-extended product; the extra sum bit is the carry out of ACC_W.
  assign prod    = PROD_W'(op_a) * PROD_W'(op_b);
  assign sum     = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  assign cnt_inc = cnt_q + 1'b1;
  assign win_len = req_len[32'(arb_winner) * LEN_W +: LEN_W];

  // Job sequencing, accumulation and output decode.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    grant        = '0;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    res_data     = '0;
    res_id       = '0;
    res_overflow = 1'b0;
    advance      = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          id_d    = arb_winner;
          len_d   = win_len;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (win_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        grant[id_q] = 1'b1;
        op_ready    = 1'b1;
        if (op_valid) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StDone;
        end
      end
      StDone: begin
        res_valid    = 1'b1;
        res_data     = acc_q;
        res_id       = id_q;
        res_overflow = ovf_q;
        if (res_ready) begin
          advance = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Scoreboard bench for mac_dot_scheduler: directed jobs push expected results,
// a negedge monitor compares every presented result and pops on handshake.
module tb_mac_dot_scheduler;
  import mac_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned OW = OP_W;
  localparam int unsigned AW = ACC_W;
  localparam int unsigned LW = LEN_W;
  localparam int unsigned IW = 2;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*LW-1:0]  req_len;
  logic [NR-1:0]     grant;
  logic              op_valid;
  logic [OW-1:0]     op_a;
  logic [OW-1:0]     op_b;
  logic              op_ready;
  logic              res_valid;
  logic              res_ready;
  logic [AW-1:0]     res_data;
  logic [IW-1:0]     res_id;
  logic              res_overflow;

  mac_dot_scheduler #(
    .NUM_REQ (NR),
    .OP_W    (OW),
    .ACC_W   (AW),
    .LEN_W   (LW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_len      (req_len),
    .grant        (grant),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_ready     (op_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_id       (res_id),
    .res_overflow (res_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] data;
    logic          ovf;
  } res_t;

  res_t              sb_q[$];
  logic [2*OW-1:0]   pair_q[$];
  int                total = 0;
  int                passed = 0;
  int                hs_cnt = 0;
  int                acc_seen = 0;
  int                stall_at = -1;
  int                stall_len = 0;
  int                stall_left = 0;
  bit                pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic timed_out(input string name);
    total++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Operand driver: the granted requester streams queued pairs, with an
  // optional stall inserted after stall_at accepted pairs.
  always @(negedge clock) begin
    if (reset) begin
      pending  = 0;
      op_valid = 1'b0;
    end else begin
      if (pending) begin
        pair_q.delete(0);
        acc_seen++;
        pending = 0;
      end
      if (stall_left > 0) begin
        op_valid = 1'b0;
        stall_left--;
      end else if (grant != '0 && stall_at >= 0 && acc_seen == stall_at) begin
        stall_at   = -1;
        stall_left = stall_len - 1;
        op_valid   = 1'b0;
      end else if (grant != '0 && pair_q.size() > 0) begin
        op_valid     = 1'b1;
        {op_a, op_b} = pair_q[0];
        pending      = op_ready;
      end else begin
        op_valid = 1'b0;
      end
    end
  end

  // Result monitor: compare every held result, pop on handshake.
  always @(negedge clock) begin
    res_t e;
    if (!reset && res_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got id %0d data %0d, expected no result",
                 res_id, res_data);
      end else begin
        e = sb_q[0];
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_overflow", 32'(res_overflow), 32'(e.ovf));
        if (res_ready) begin
          sb_q.delete(0);
          hs_cnt++;
        end
      end
    end
  end

  task automatic wait_hs(input int target, input string name);
    bit ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      if (hs_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timed_out(name);
  endtask

  task automatic do_job(input int id, input int len, input int data, input bit ovf,
                        input string name);
    res_t e;
    int   h;
    e.id   = IW'(id);
    e.data = AW'(data);
    e.ovf  = ovf;
    sb_q.push_back(e);
    req_len[id*LW +: LW] = LW'(len);
    req_valid[id] = 1'b1;
    h = hs_cnt;
    wait_hs(h + 1, name);
    req_valid[id] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_op_ready"}, 32'(op_ready), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_res_id"}, 32'(res_id), 0);
    check({tag, "_res_overflow"}, 32'(res_overflow), 0);
  endtask

  initial begin
    res_t e;
    int   h0;
    bit   ok;
    reset = 1'b1; req_valid = '0; req_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // All four requesters at once, len 1, pair (1,1): served 0,1,2,3.
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      pair_q.push_back({4'd1, 4'd1});
      e.id = IW'(i); e.data = AW'(1); e.ovf = 1'b0;
      sb_q.push_back(e);
    end
    req_len = {4{4'd1}};
    req_valid = 4'hf;
    for (int k = 0; k < 4; k++) begin
      wait_hs(h0 + k + 1, "rr_all");
      req_valid[k] = 1'b0;
    end
    pair_q.push_back({4'd1, 4'd1});
    do_job(0, 1, 1, 1'b0, "rr_again0");

    // req0 len 3: grant for 3 cycles, result 6+20+225 = 251 on the 4th.
    pair_q.push_back({4'd2, 4'd3});
    pair_q.push_back({4'd4, 4'd5});
    pair_q.push_back({4'd15, 4'd15});
    e.id = 0; e.data = AW'(251); e.ovf = 1'b0;
    sb_q.push_back(e);
    req_len[3:0] = 4'd3;
    req_valid = 4'b0001;
    h0 = hs_cnt;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock); #1;
      check("len3_grant", 32'(grant), 32'h1);
    end
    @(posedge clock); #1;
    check("len3_res_valid", 32'(res_valid), 1);
    wait_hs(h0 + 1, "len3");
    req_valid = '0;

    // req2 len 0: straight to the result, no operand phase.
    e.id = 2; e.data = 0; e.ovf = 1'b0;
    sb_q.push_back(e);
    req_len[11:8] = 4'd0;
    req_valid = 4'b0100;
    h0 = hs_cnt;
    @(posedge clock); #1;
    check("len0_grant", 32'(grant), 0);
    check("len0_op_ready", 32'(op_ready), 0);
    check("len0_res_valid", 32'(res_valid), 1);
    wait_hs(h0 + 1, "len0");
    req_valid = '0;

    // req1 len 5 of (15,15): 1125 wraps to 101 with overflow.
    for (int i = 0; i < 5; i++) pair_q.push_back({4'd15, 4'd15});
    do_job(1, 5, 101, 1'b1, "overflow");

    // Stall 2 cycles after 2 pairs, then hold the result 3 cycles.
    acc_seen = 0; stall_at = 2; stall_len = 2;
    pair_q.push_back({4'd1, 4'd2});
    pair_q.push_back({4'd3, 4'd4});
    pair_q.push_back({4'd5, 4'd6});
    pair_q.push_back({4'd7, 4'd8});
    e.id = 0; e.data = AW'(100); e.ovf = 1'b0;
    sb_q.push_back(e);
    res_ready = 1'b0;
    req_len[3:0] = 4'd4;
    req_valid = 4'b0001;
    h0 = hs_cnt;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timed_out("stall_res_valid");
    repeat (3) @(posedge clock);
    #1;
    check("bp_no_handshake", 32'(hs_cnt), 32'(h0));
    res_ready = 1'b1;
    wait_hs(h0 + 1, "stall");
    req_valid = '0;
    repeat (3) @(posedge clock);
    #1;
    check("bp_one_handshake", 32'(hs_cnt), 32'(h0 + 1));

    // Reset after 2 of 4 pairs: outputs clear at once, job discarded.
    acc_seen = 0;
    for (int i = 0; i < 4; i++) pair_q.push_back({4'd2, 4'd2});
    req_len[3:0] = 4'd4;
    req_valid = 4'b0001;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock); #1;
      if (acc_seen >= 2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timed_out("reset_midjob_wait");
    check("pre_reset_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    #1;
    check_all_zero("midjob_reset");
    pair_q.delete();
    req_valid = '0;
    pending = 0;
    op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    pair_q.push_back({4'd3, 4'd3});
    do_job(3, 1, 9, 1'b0, "post_reset");

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    check("handshake_total", 32'(hs_cnt), 10);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
